// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Optional feature macro used by spi_reg_ctrl: SPI_REG_AUTOINC_EN.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_BUS,
        ST_RD_BUS,
        ST_RD_HOLD
    } spi_reg_state_t;

    localparam int         CMD_RD_BIT      = 7;
    localparam logic [7:0] ERR_STATUS_MASK = 8'h80;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Command/data register-access protocol over a one-byte-per-frame SPI slave.
// Define SPI_REG_AUTOINC_EN for address auto-increment with open-ended data phase.
import spi_reg_pkg::*;

module spi_reg_ctrl #(
    parameter int ADDR_W   = 7,
    parameter int IDLE_TMO = 1024,
    parameter int BUS_TMO  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        spi_data_in,
    input  logic              spi_end_of_byte,
    input  logic              spi_busy,
    output logic [7:0]        spi_data_out,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_ack,
    output logic              err,
    input  logic              err_clr
);

    localparam int MAX_TMO = (IDLE_TMO > BUS_TMO) ? IDLE_TMO : BUS_TMO;
    localparam int CNT_W   = $clog2(MAX_TMO + 1);

    spi_reg_state_t    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        dout_q, dout_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              err_q, err_d;
    logic              eob_q, busy_q;
    logic [CNT_W-1:0]  bus_cnt_q, bus_cnt_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;

    logic byte_stb, frame_end, busy_rise, new_err;
    logic bus_tmo, idle_tmo;

    assign byte_stb  = spi_end_of_byte & ~eob_q;
    assign frame_end = ~spi_busy & busy_q;
    assign busy_rise = spi_busy & ~busy_q;
    assign bus_tmo   = (bus_cnt_q == CNT_W'(BUS_TMO - 1));
    assign idle_tmo  = (idle_cnt_q == CNT_W'(IDLE_TMO - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        we_d       = we_q;
        re_d       = re_q;
        new_err    = 1'b0;
        bus_cnt_d  = '0;
        idle_cnt_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                dout_d = err_q ? ERR_STATUS_MASK : 8'h00;
                if (byte_stb) begin
                    addr_d = spi_data_in[ADDR_W-1:0];
                    if (spi_data_in[CMD_RD_BIT]) begin
                        re_d    = 1'b1;
                        state_d = ST_RD_BUS;
                    end else begin
                        state_d = ST_WR_WAIT;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (byte_stb) begin
                    wdata_d = spi_data_in;
                    we_d    = 1'b1;
                    state_d = ST_WR_BUS;
                end else if (!spi_busy) begin
                    if (idle_tmo) state_d = ST_IDLE;
                    else idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_WR_BUS: begin
                // A byte landing here is a host overrun; it is dropped.
                if (byte_stb) new_err = 1'b1;
                if (reg_ack) begin
                    we_d = 1'b0;
`ifdef SPI_REG_AUTOINC_EN
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_WR_WAIT;
`else
                    state_d = ST_IDLE;
`endif
                end else if (bus_tmo) begin
                    new_err = 1'b1;
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    bus_cnt_d = bus_cnt_q + 1'b1;
                end
            end
            ST_RD_BUS: begin
                if (byte_stb) new_err = 1'b1;
                if (busy_rise) begin
                    new_err = 1'b1;
                    re_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (reg_ack) begin
                    dout_d  = reg_rdata;
                    re_d    = 1'b0;
                    state_d = ST_RD_HOLD;
                end else if (bus_tmo) begin
                    new_err = 1'b1;
                    re_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    bus_cnt_d = bus_cnt_q + 1'b1;
                end
            end
            ST_RD_HOLD: begin
                if (frame_end) begin
`ifdef SPI_REG_AUTOINC_EN
                    addr_d  = addr_q + 1'b1;
                    re_d    = 1'b1;
                    state_d = ST_RD_BUS;
`else
                    state_d = ST_IDLE;
`endif
                end else if (!spi_busy) begin
                    if (idle_tmo) state_d = ST_IDLE;
                    else idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_d = err_clr ? 1'b0 : (err_q | new_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            dout_q     <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            err_q      <= 1'b0;
            eob_q      <= 1'b0;
            busy_q     <= 1'b0;
            bus_cnt_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
            we_q       <= we_d;
            re_q       <= re_d;
            err_q      <= err_d;
            eob_q      <= spi_end_of_byte;
            busy_q     <= spi_busy;
            bus_cnt_q  <= bus_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign spi_data_out = dout_q;
    assign reg_addr     = addr_q;
    assign reg_wdata    = wdata_q;
    assign reg_we       = we_q;
    assign reg_re       = re_q;
    assign err          = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl; SPI_REG_AUTOINC_EN selects the autoinc checks.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] spi_data_in = 8'h00;
    logic       spi_end_of_byte = 1'b0;
    logic       spi_busy = 1'b0;
    logic [7:0] spi_data_out;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_ack = 1'b0;
    logic       err;
    logic       err_clr = 1'b0;

    spi_reg_ctrl #(.ADDR_W(7), .IDLE_TMO(1024), .BUS_TMO(64)) dut (
        .clk(clk), .rst(rst),
        .spi_data_in(spi_data_in), .spi_end_of_byte(spi_end_of_byte),
        .spi_busy(spi_busy), .spi_data_out(spi_data_out),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rd;
        logic [6:0] addr;
        logic [7:0] data;
    } bus_t;

    bus_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   ack_dly = 3;
    bit   ack_en = 1'b1;
    int   req_cyc = 0;
    int   re_len = 0;
    bit   we_prev = 1'b0;
    bit   re_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit rd, input logic [6:0] a, input logic [7:0] d);
        bus_t e;
        e.rd = rd;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b);
        @(negedge clk);
        spi_busy = 1'b1;
        spi_end_of_byte = 1'b0;
        repeat (4) @(negedge clk);
        spi_data_in = b;
        spi_end_of_byte = 1'b1;
        @(negedge clk);
        spi_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
`ifdef SPI_REG_AUTOINC_EN
        repeat (1100) @(negedge clk);
`else
        repeat (6) @(negedge clk);
`endif
    endtask

    // Register-bus responder: ack after ack_dly request cycles.
    always @(negedge clk) begin
        if (reg_ack) begin
            reg_ack = 1'b0;
            req_cyc = 0;
        end else if ((reg_we || reg_re) && ack_en) begin
            req_cyc++;
            if (req_cyc >= ack_dly) reg_ack = 1'b1;
        end else begin
            req_cyc = 0;
        end
    end

    // Bus monitor: each new request is popped against the scoreboard.
    always @(negedge clk) begin
        bus_t e;
        if (reg_re) re_len = re_prev ? re_len + 1 : 1;
        if ((reg_we && !we_prev) || (reg_re && !re_prev)) begin
            if (exp_q.size() == 0) begin
                chk("bus_unexp", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("bus_rd", 32'(reg_re), 32'(e.rd));
                chk("bus_addr", 32'(reg_addr), 32'(e.addr));
                if (!e.rd) chk("bus_wdata", 32'(reg_wdata), 32'(e.data));
            end
        end
        we_prev = reg_we;
        re_prev = reg_re;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dout", 32'(spi_data_out), 32'h00);
        chk("rst_addr", 32'(reg_addr), 32'h00);
        chk("rst_wdata", 32'(reg_wdata), 32'h00);
        chk("rst_we", 32'(reg_we), 32'h0);
        chk("rst_re", 32'(reg_re), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // Single write
        push(1'b0, 7'h05, 8'hA5);
        send_frame(8'h05);
        send_frame(8'hA5);
        repeat (5) @(negedge clk);
        chk("wr_we_done", 32'(reg_we), 32'h0);
        chk("wr_err", 32'(err), 32'h0);
        settle();

        // Single read, data must be ready before the second frame
        reg_rdata = 8'h3C;
        push(1'b1, 7'h03, 8'h00);
        send_frame(8'h83);
        repeat (6) @(negedge clk);
        chk("rd_dout", 32'(spi_data_out), 32'h3C);
        chk("rd_re_done", 32'(reg_re), 32'h0);
`ifdef SPI_REG_AUTOINC_EN
        push(1'b1, 7'h04, 8'h00);
`endif
        send_frame(8'h00);
        repeat (6) @(negedge clk);
`ifdef SPI_REG_AUTOINC_EN
        chk("rd2_dout", 32'(spi_data_out), 32'h3C);
`else
        chk("rd_idle_dout", 32'(spi_data_out), 32'h00);
`endif
        settle();

`ifdef SPI_REG_AUTOINC_EN
        // Autoinc write with address wrap
        ack_dly = 2;
        push(1'b0, 7'h7F, 8'h11);
        push(1'b0, 7'h00, 8'h22);
        push(1'b0, 7'h01, 8'h33);
        send_frame(8'h7F);
        send_frame(8'h11);
        send_frame(8'h22);
        send_frame(8'h33);
        settle();
        chk("ai_addr", 32'(reg_addr), 32'h02);
        push(1'b0, 7'h06, 8'h5A);
        send_frame(8'h06);
        send_frame(8'h5A);
        settle();
`endif

        // Bus timeout on a read
        ack_en = 1'b0;
        push(1'b1, 7'h01, 8'h00);
        send_frame(8'h81);
        repeat (80) @(negedge clk);
        chk("tmo_re", 32'(reg_re), 32'h0);
        chk("tmo_len", 32'(re_len), 32'd64);
        chk("tmo_err", 32'(err), 32'h1);
        chk("tmo_status", 32'(spi_data_out), 32'h80);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("clr_err", 32'(err), 32'h0);
        chk("clr_status", 32'(spi_data_out), 32'h00);
        ack_en = 1'b1;

        // Overrun: next frame starts before the read ack
        ack_dly = 20;
        reg_rdata = 8'hE7;
        push(1'b1, 7'h04, 8'h00);
        send_frame(8'h84);
        spi_busy = 1'b1;
        spi_end_of_byte = 1'b0;
        repeat (3) @(negedge clk);
        spi_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovr_err", 32'(err), 32'h1);
        chk("ovr_re", 32'(reg_re), 32'h0);
        chk("ovr_dout", 32'(spi_data_out), 32'h80);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        ack_dly = 3;

        // Reset while a write is outstanding
        ack_en = 1'b0;
        push(1'b0, 7'h10, 8'h77);
        send_frame(8'h10);
        send_frame(8'h77);
        @(negedge clk);
        chk("pre_rst_we", 32'(reg_we), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_we", 32'(reg_we), 32'h0);
        chk("mid_rst_addr", 32'(reg_addr), 32'h00);
        chk("mid_rst_wdata", 32'(reg_wdata), 32'h00);
        chk("mid_rst_dout", 32'(spi_data_out), 32'h00);
        chk("mid_rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_we", 32'(reg_we), 32'h0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
